// File: rtl/muldiv_wb_sched_if.sv
// Issue/result bundle between the MUL/DIV issue queue, the arithmetic units and the
// writeback scheduler. The slave modport is the scheduler's view.
interface muldiv_wb_sched_if #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 32
);
  logic [IN_W-1:0]  fuinput_i;
  logic             fuinput_i_valid;
  logic             fuinput_i_is_div;
  logic             fuinput_i_ready;
  logic             mul_i_valid;
  logic [OUT_W-1:0] mul_o;
  logic             mul_o_valid;
  logic             div_i_valid;
  logic             div_i_ready;
  logic [OUT_W-1:0] div_o;
  logic             div_o_valid;
  logic             div_o_ready;
  logic [OUT_W-1:0] fuoutput_o;
  logic             fuoutput_o_valid;

  modport slave (
    input  fuinput_i, fuinput_i_valid, fuinput_i_is_div,
    input  mul_o, mul_o_valid,
    input  div_i_ready, div_o, div_o_valid,
    output fuinput_i_ready, mul_i_valid, div_i_valid, div_o_ready,
    output fuoutput_o, fuoutput_o_valid
  );

  modport master (
    output fuinput_i, fuinput_i_valid, fuinput_i_is_div,
    output mul_o, mul_o_valid,
    output div_i_ready, div_o, div_o_valid,
    input  fuinput_i_ready, mul_i_valid, div_i_valid, div_o_ready,
    input  fuoutput_o, fuoutput_o_valid
  );
endinterface

// File: rtl/muldiv_wb_sched.sv
// Shares one writeback port between a fixed-latency multiplier and an iterative divider;
// a stalled divider result is held and, if starved, a multiplier issue bubble is forced.
module muldiv_wb_sched #(
  parameter int MUL_LAT    = 2,
  parameter int STARVE_MAX = 4,
  parameter int OUT_W      = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             squash,
  muldiv_wb_sched_if.slave bus
);
  typedef enum logic [1:0] {
    H_EMPTY = 2'd0,
    H_WAIT  = 2'd1,
    H_FORCE = 2'd2
  } hold_state_e;

  localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);
  localparam logic [3:0] BUBBLE_LAST = 4'(MUL_LAT);

  hold_state_e      state_r;
  hold_state_e      state_nxt_s;
  logic [3:0]       starve_r;
  logic [3:0]       starve_nxt_s;
  logic [3:0]       bubble_r;
  logic [3:0]       bubble_nxt_s;
  logic [OUT_W-1:0] hold_r;
  logic             hold_valid_s;
  logic             block_mul_s;
  logic             div_acc_s;
  logic             sel_mul_s;
  logic             sel_hold_s;
  logic             sel_div_s;
  logic             cap_s;

  assign hold_valid_s    = (state_r != H_EMPTY);
  assign block_mul_s     = (state_r == H_FORCE) && (bubble_r == 4'd0);
  assign bus.div_o_ready = ~hold_valid_s;

  assign bus.mul_i_valid     = bus.fuinput_i_valid & ~bus.fuinput_i_is_div & ~block_mul_s & ~squash;
  assign bus.div_i_valid     = bus.fuinput_i_valid & bus.fuinput_i_is_div & bus.div_i_ready & ~squash;
  assign bus.fuinput_i_ready = bus.fuinput_i_is_div ? bus.div_i_ready : ~block_mul_s;

  // Multiplier results always win; a divider result colliding with one is parked in hold
  assign div_acc_s  = bus.div_o_valid & ~hold_valid_s;
  assign sel_mul_s  = bus.mul_o_valid;
  assign sel_hold_s = hold_valid_s & ~bus.mul_o_valid;
  assign sel_div_s  = div_acc_s & ~bus.mul_o_valid;
  assign cap_s      = div_acc_s & bus.mul_o_valid;

  // Hold FSM next-state and counter update
  always_comb begin
    state_nxt_s  = state_r;
    starve_nxt_s = starve_r;
    bubble_nxt_s = bubble_r;
    if (squash) begin
      state_nxt_s  = H_EMPTY;
      starve_nxt_s = 4'd0;
      bubble_nxt_s = 4'd0;
    end else begin
      case (state_r)
        H_EMPTY: begin
          if (cap_s) begin
            state_nxt_s  = H_WAIT;
            starve_nxt_s = 4'd0;
          end else begin
            state_nxt_s = H_EMPTY;
          end
        end
        H_WAIT: begin
          if (sel_hold_s) begin
            state_nxt_s  = H_EMPTY;
            starve_nxt_s = 4'd0;
          end else if (starve_r == STARVE_LAST) begin
            state_nxt_s  = H_FORCE;
            bubble_nxt_s = 4'd0;
          end else begin
            starve_nxt_s = starve_r + 4'd1;
          end
        end
        H_FORCE: begin
          // The blocked issue slot reaches writeback MUL_LAT cycles later, so the drain is bounded
          if (sel_hold_s) begin
            state_nxt_s  = H_EMPTY;
            starve_nxt_s = 4'd0;
            bubble_nxt_s = 4'd0;
          end else if (bubble_r != BUBBLE_LAST) begin
            bubble_nxt_s = bubble_r + 4'd1;
          end else begin
            bubble_nxt_s = bubble_r;
          end
        end
        default: begin
          state_nxt_s  = H_EMPTY;
          starve_nxt_s = 4'd0;
          bubble_nxt_s = 4'd0;
        end
      endcase
    end
  end

  // Hold FSM state and counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= H_EMPTY;
      starve_r <= 4'd0;
      bubble_r <= 4'd0;
    end else begin
      state_r  <= state_nxt_s;
      starve_r <= starve_nxt_s;
      bubble_r <= bubble_nxt_s;
    end
  end

  // Hold buffer payload
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_r <= '0;
    end else if (squash) begin
      hold_r <= '0;
    end else if (cap_s) begin
      hold_r <= bus.div_o;
    end
  end

  // Registered writeback mux
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.fuoutput_o       <= '0;
      bus.fuoutput_o_valid <= 1'b0;
    end else if (squash) begin
      bus.fuoutput_o_valid <= 1'b0;
    end else if (sel_mul_s) begin
      bus.fuoutput_o       <= bus.mul_o;
      bus.fuoutput_o_valid <= 1'b1;
    end else if (sel_hold_s) begin
      bus.fuoutput_o       <= hold_r;
      bus.fuoutput_o_valid <= 1'b1;
    end else if (sel_div_s) begin
      bus.fuoutput_o       <= bus.div_o;
      bus.fuoutput_o_valid <= 1'b1;
    end else begin
      bus.fuoutput_o_valid <= 1'b0;
    end
  end

  muldiv_wb_sched_chk #(.MUL_LAT(MUL_LAT)) u_chk (
    .clk         (clk),
    .rstn        (rstn),
    .sel_mul     (sel_mul_s),
    .sel_hold    (sel_hold_s),
    .sel_div     (sel_div_s),
    .block_mul   (block_mul_s),
    .mul_o_valid (bus.mul_o_valid)
  );
endmodule

// Protocol checks for the writeback scheduler.
module muldiv_wb_sched_chk #(
  parameter int MUL_LAT = 2
) (
  input logic clk,
  input logic rstn,
  input logic sel_mul,
  input logic sel_hold,
  input logic sel_div,
  input logic block_mul,
  input logic mul_o_valid
);
  logic [MUL_LAT-1:0] blk_hist_r;

  // History of blocked issue slots, oldest in the MSB
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blk_hist_r <= '0;
    end else begin
      blk_hist_r <= MUL_LAT'({blk_hist_r, block_mul});
    end
  end

  a_one_sel: assert property (@(posedge clk) disable iff (!rstn)
    $onehot0({sel_mul, sel_hold, sel_div}));

  a_free_slot: assert property (@(posedge clk) disable iff (!rstn)
    blk_hist_r[MUL_LAT-1] |-> !mul_o_valid);
endmodule
